coprocessor_dispatcher: RTL and testbench

Host-side initiator that feeds the coprocessor (processor) with work over the index handshake.
- Fetches a job descriptor block from shared memory and publishes the config word and mu.
- Issues each row/col index pair with index_ready/index_ack, then hands memory ownership to the processor via grant until result_ready.
- Owns the memory port whenever grant is low; an external mux selects the processor's memory signals while out_grant=1.

---
 rtl/coprocessor_dispatcher_pkg.sv | 33 +++
 rtl/coprocessor_dispatcher.sv | 161 ++++++++++++++++
 tb/tb_coprocessor_dispatcher.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/coprocessor_dispatcher_pkg.sv
// Shared definitions for the coprocessor dispatcher: FSM states, descriptor
// field positions and the cell slots used inside descriptor and job lines.
package coprocessor_dispatcher_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RD_CFG,
        WAIT_CFG,
        RD_JOB,
        WAIT_JOB,
        ISSUE,
        RUN,
        COMPLETE,
        FIN
    } dispatch_state_t;

    // Config word layout: mu sits in [23:16], gamma in [15:8], lambda in [7:0].
    localparam int MU_HI = 23;
    localparam int MU_LO = 16;

    typedef struct packed {
        logic [7:0] reserved;
        logic [7:0] mu;
        logic [7:0] gamma;
        logic [7:0] lambda;
    } config_fields_t;

    localparam int CFG_CELL   = 0;
    localparam int COUNT_CELL = 1;
    localparam int ROW_CELL   = 0;
    localparam int COL_CELL   = 1;

endpackage

// File: rtl/coprocessor_dispatcher.sv
// Host-side dispatcher: reads a job descriptor block, then hands each row/col
// pair to the coprocessor and lends it the memory port until the job finishes.
module coprocessor_dispatcher
    import coprocessor_dispatcher_pkg::*;
#(
    parameter int size             = 3,
    parameter int cell_width       = 32,
    parameter int index_width      = 8,
    parameter int width            = cell_width * size,
    parameter int memory_size      = 256,
    parameter int memory_size_log  = 8,
    parameter int job_base_address = 0
) (
    input  logic                       in_clk,
    input  logic                       in_reset,
    input  logic                       in_start,
    input  logic [width-1:0]           in_mem_data,
    input  logic                       in_index_ack,
    input  logic                       in_result_ready,
    output logic                       out_mem_read_en,
    output logic [memory_size_log-1:0] out_mem_address,
    output logic                       out_grant,
    output logic [index_width-1:0]     out_row_index,
    output logic [index_width-1:0]     out_col_index,
    output logic                       out_index_ready,
    output logic [index_width-1:0]     out_mu,
    output logic [cell_width-1:0]      out_Config,
    output logic                       out_busy,
    output logic                       out_done,
    output logic [index_width-1:0]     out_jobs_done
);

    localparam int ADDR_CALC_W = memory_size_log + index_width + 8;

    dispatch_state_t             state_reg;
    logic [index_width-1:0]      k_reg;
    logic [index_width-1:0]      count_reg;
    logic [index_width-1:0]      k_next;

    logic [cell_width-1:0]       desc_config;
    logic [index_width-1:0]      desc_count;
    logic [index_width-1:0]      job_row;
    logic [index_width-1:0]      job_col;
    logic                        unused_mem_bits;

    assign desc_config     = in_mem_data[CFG_CELL*cell_width +: cell_width];
    assign desc_count      = in_mem_data[COUNT_CELL*cell_width +: index_width];
    assign job_row         = in_mem_data[ROW_CELL*cell_width +: index_width];
    assign job_col         = in_mem_data[COL_CELL*cell_width +: index_width];
    assign unused_mem_bits = ^in_mem_data;
    assign k_next          = k_reg + index_width'(1);

    // Job k occupies the line after the descriptor and k earlier job lines;
    // the address wraps around the memory.
    function automatic logic [memory_size_log-1:0] job_line(input logic [index_width-1:0] idx);
        logic [ADDR_CALC_W-1:0] full;
        full = ADDR_CALC_W'(job_base_address)
             + ADDR_CALC_W'(size) * (ADDR_CALC_W'(idx) + ADDR_CALC_W'(1));
        return memory_size_log'(full % ADDR_CALC_W'(memory_size));
    endfunction

    always_ff @(posedge in_clk) begin
        if (!in_reset) begin
            state_reg       <= IDLE;
            k_reg           <= '0;
            count_reg       <= '0;
            out_mem_read_en <= 1'b0;
            out_mem_address <= '0;
            out_grant       <= 1'b0;
            out_row_index   <= '0;
            out_col_index   <= '0;
            out_index_ready <= 1'b0;
            out_mu          <= '0;
            out_Config      <= '0;
            out_busy        <= 1'b0;
            out_done        <= 1'b0;
            out_jobs_done   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_start) begin
                        state_reg       <= RD_CFG;
                        out_busy        <= 1'b1;
                        out_jobs_done   <= '0;
                        k_reg           <= '0;
                        out_mem_read_en <= 1'b1;
                        out_mem_address <= memory_size_log'(job_base_address);
                    end
                end
                RD_CFG: begin
                    state_reg       <= WAIT_CFG;
                    out_mem_read_en <= 1'b0;
                    out_mem_address <= '0;
                end
                WAIT_CFG: begin
                    out_Config <= desc_config;
                    out_mu     <= desc_config[MU_HI:MU_LO];
                    count_reg  <= desc_count;
                    if (desc_count == '0) begin
                        state_reg <= FIN;
                        out_done  <= 1'b1;
                        out_busy  <= 1'b0;
                    end else begin
                        state_reg       <= RD_JOB;
                        out_mem_read_en <= 1'b1;
                        out_mem_address <= job_line(k_reg);
                    end
                end
                RD_JOB: begin
                    state_reg       <= WAIT_JOB;
                    out_mem_read_en <= 1'b0;
                    out_mem_address <= '0;
                end
                WAIT_JOB: begin
                    state_reg       <= ISSUE;
                    out_row_index   <= job_row;
                    out_col_index   <= job_col;
                    out_grant       <= 1'b1;
                    out_index_ready <= 1'b1;
                end
                ISSUE: begin
                    // A processor that finishes in the accepting cycle skips RUN.
                    if (in_index_ack) begin
                        out_index_ready <= 1'b0;
                        if (in_result_ready) begin
                            state_reg <= COMPLETE;
                            out_grant <= 1'b0;
                        end else begin
                            state_reg <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (in_result_ready) begin
                        state_reg <= COMPLETE;
                        out_grant <= 1'b0;
                    end
                end
                COMPLETE: begin
                    out_jobs_done <= out_jobs_done + index_width'(1);
                    k_reg         <= k_next;
                    if (k_next == count_reg) begin
                        state_reg <= FIN;
                        out_done  <= 1'b1;
                        out_busy  <= 1'b0;
                    end else begin
                        state_reg       <= RD_JOB;
                        out_mem_read_en <= 1'b1;
                        out_mem_address <= job_line(k_next);
                    end
                end
                FIN: begin
                    state_reg <= IDLE;
                    out_done  <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coprocessor_dispatcher.sv
// Bench for coprocessor_dispatcher: builds a per-cycle expected timeline from
// the descriptor contents and processor timing, then plays it against the DUT.
module tb_coprocessor_dispatcher;

    localparam int SIZE = 3;
    localparam int CW   = 32;
    localparam int IW   = 8;
    localparam int W    = CW * SIZE;
    localparam int MS   = 256;
    localparam int MSL  = 8;
    localparam int BASE = 252;

    logic          clk = 1'b0;
    logic          in_reset;
    logic          in_start;
    logic [W-1:0]  in_mem_data;
    logic          in_index_ack;
    logic          in_result_ready;
    logic          out_mem_read_en;
    logic [MSL-1:0] out_mem_address;
    logic          out_grant;
    logic [IW-1:0] out_row_index;
    logic [IW-1:0] out_col_index;
    logic          out_index_ready;
    logic [IW-1:0] out_mu;
    logic [CW-1:0] out_Config;
    logic          out_busy;
    logic          out_done;
    logic [IW-1:0] out_jobs_done;

    always #5 clk = ~clk;

    coprocessor_dispatcher #(
        .size(SIZE), .cell_width(CW), .index_width(IW), .width(W),
        .memory_size(MS), .memory_size_log(MSL), .job_base_address(BASE)
    ) dut (
        .in_clk(clk), .in_reset(in_reset), .in_start(in_start),
        .in_mem_data(in_mem_data), .in_index_ack(in_index_ack),
        .in_result_ready(in_result_ready), .out_mem_read_en(out_mem_read_en),
        .out_mem_address(out_mem_address), .out_grant(out_grant),
        .out_row_index(out_row_index), .out_col_index(out_col_index),
        .out_index_ready(out_index_ready), .out_mu(out_mu), .out_Config(out_Config),
        .out_busy(out_busy), .out_done(out_done), .out_jobs_done(out_jobs_done)
    );

    // One entry per clock: inputs for that cycle and the outputs visible in it.
    typedef struct {
        logic         rst_n, start, ack, res;
        logic [W-1:0] mem;
        logic [76:0]  exp_out;
    } step_t;

    step_t        sched[$];
    logic [31:0]  cells[MS];
    logic [31:0]  e_cfg;
    logic [7:0]   e_mu, e_row, e_col, e_jobs;
    logic         e_busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  rd_log[$];
    logic [15:0] pair_log[$];
    int start_idx, first_ready, done_idx, done_cnt;
    logic [7:0] done_jobs;
    logic grant_seen;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [W-1:0] garbage();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [W-1:0] line_at(input int a);
        return {cells[(a + 2) % MS], cells[(a + 1) % MS], cells[a % MS]};
    endfunction

    function automatic int job_addr(input int k);
        return (BASE + SIZE * (k + 1)) % MS;
    endfunction

    task automatic push(input logic rd, input logic [7:0] addr, input logic grant,
                        input logic ready, input logic done, input logic rst_n,
                        input logic start, input logic ack, input logic res,
                        input logic [W-1:0] mem);
        step_t s;
        s.rst_n = rst_n; s.start = start; s.ack = ack; s.res = res; s.mem = mem;
        s.exp_out = {rd, addr, grant, ready, e_busy, done, e_row, e_col, e_mu, e_cfg, e_jobs};
        sched.push_back(s);
    endtask

    task automatic fill_random(input int n);
        cells[BASE]     = $urandom();
        cells[BASE + 1] = {24'($urandom()), 8'(n)};
        cells[BASE + 2] = $urandom();
        for (int k = 0; k < n; k++) begin
            cells[job_addr(k)]            = $urandom();
            cells[(job_addr(k) + 1) % MS] = $urandom();
            cells[(job_addr(k) + 2) % MS] = $urandom();
        end
    endtask

    // mode 0: random processor timing, 1: ack after 1 cycle and result 5 later,
    // 2: ack and result together. abort: reset is pulled in RUN of job 0.
    task automatic build_run(input int mode, input bit abort);
        logic [W-1:0] d, j;
        int n, wa, wr;
        bit same;
        e_busy = 1'b0;
        push(0, 0, 0, 0, 0, 1, 0, rb(), rb(), garbage());
        push(0, 0, 0, 0, 0, 1, 1, rb(), rb(), garbage());
        e_busy = 1'b1;
        e_jobs = 8'd0;
        push(1, 8'(BASE), 0, 0, 0, 1, 1, rb(), rb(), garbage());
        d = line_at(BASE);
        push(0, 0, 0, 0, 0, 1, rb(), rb(), rb(), d);
        e_cfg = d[31:0];
        e_mu  = d[23:16];
        n     = int'(d[39:32]);
        for (int k = 0; k < n; k++) begin
            push(1, 8'(job_addr(k)), 0, 0, 0, 1, rb(), rb(), rb(), garbage());
            j = line_at(job_addr(k));
            push(0, 0, 0, 0, 0, 1, rb(), rb(), rb(), j);
            e_row = j[7:0];
            e_col = j[39:32];
            case (mode)
                1:       begin wa = 1; wr = 4; same = 1'b0; end
                2:       begin wa = $urandom_range(0, 2); wr = 0; same = 1'b1; end
                default: begin wa = $urandom_range(0, 3); wr = $urandom_range(0, 5);
                               same = ($urandom_range(0, 3) == 0); end
            endcase
            if (abort) begin
                same = 1'b0;
                if (wr < 2) wr = 2;
            end
            for (int i = 0; i < wa; i++) push(0, 0, 1, 1, 0, 1, rb(), 0, 0, garbage());
            if (same) begin
                push(0, 0, 1, 1, 0, 1, rb(), 1, 1, garbage());
            end else begin
                push(0, 0, 1, 1, 0, 1, rb(), 1, 0, garbage());
                for (int i = 0; i < wr; i++) begin
                    if (abort && i == 1) begin
                        push(0, 0, 1, 0, 0, 0, 0, 0, 0, garbage());
                        e_cfg = '0; e_mu = '0; e_row = '0; e_col = '0; e_jobs = '0; e_busy = 1'b0;
                        push(0, 0, 0, 0, 0, 1, 0, 0, 0, garbage());
                        return;
                    end
                    push(0, 0, 1, 0, 0, 1, rb(), 0, 0, garbage());
                end
                push(0, 0, 1, 0, 0, 1, rb(), 0, 1, garbage());
            end
            push(0, 0, 0, 0, 0, 1, rb(), rb(), rb(), garbage());
            e_jobs = e_jobs + 8'd1;
        end
        e_busy = 1'b0;
        push(0, 0, 0, 0, 1, 1, 0, rb(), rb(), garbage());
        push(0, 0, 0, 0, 0, 1, 0, rb(), rb(), garbage());
    endtask

    task automatic play();
        logic [76:0] act;
        logic prev_ready = 1'b0;
        rd_log.delete();
        pair_log.delete();
        start_idx = -1; first_ready = -1; done_idx = -1; done_cnt = 0;
        done_jobs = 8'hxx; grant_seen = 1'b0;
        for (int i = 0; i < sched.size(); i++) begin
            @(negedge clk);
            act = {out_mem_read_en, out_mem_address, out_grant, out_index_ready, out_busy,
                   out_done, out_row_index, out_col_index, out_mu, out_Config, out_jobs_done};
            n_checks++;
            if (act !== sched[i].exp_out) begin
                n_errors++;
                $display("FAIL cycle_outputs step %0d: got %h expected %h {rd,addr,grant,rdy,busy,done,row,col,mu,cfg,jobs}",
                         i, act, sched[i].exp_out);
            end
            if (out_mem_read_en === 1'b1) rd_log.push_back(out_mem_address);
            if (out_grant === 1'b1) grant_seen = 1'b1;
            if (out_index_ready === 1'b1 && !prev_ready) begin
                pair_log.push_back({out_row_index, out_col_index});
                if (first_ready < 0) first_ready = i;
            end
            prev_ready = (out_index_ready === 1'b1);
            if (out_done === 1'b1) begin
                done_cnt++;
                done_idx  = i;
                done_jobs = out_jobs_done;
            end
            if (sched[i].start && start_idx < 0) start_idx = i;
            in_reset        = sched[i].rst_n;
            in_start        = sched[i].start;
            in_index_ack    = sched[i].ack;
            in_result_ready = sched[i].res;
            in_mem_data     = sched[i].mem;
        end
        sched.delete();
    endtask

    task automatic check_lit(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        in_reset = 1'b0; in_start = 1'b0; in_index_ack = 1'b0;
        in_result_ready = 1'b0; in_mem_data = '0;
        for (int i = 0; i < MS; i++) cells[i] = $urandom();
        e_cfg = '0; e_mu = '0; e_row = '0; e_col = '0; e_jobs = '0; e_busy = 1'b0;

        // Reset state, then the two-job descriptor with fixed processor timing.
        push(0, 0, 0, 0, 0, 0, 0, rb(), rb(), garbage());
        push(0, 0, 0, 0, 0, 0, 0, rb(), rb(), garbage());
        cells[252] = 32'h0005_0201; cells[253] = 32'h0000_0002;
        cells[255] = 32'h0000_0000; cells[0]   = 32'h0000_0001;
        cells[2]   = 32'h0000_0002; cells[3]   = 32'h0000_0002;
        build_run(1, 1'b0);
        play();
        check_lit("reads_count", rd_log.size(), 3);
        check_lit("read0_addr", rd_log.size() > 0 ? rd_log[0] : 8'hxx, 252);
        check_lit("read1_addr", rd_log.size() > 1 ? rd_log[1] : 8'hxx, 255);
        check_lit("read2_addr_wrap", rd_log.size() > 2 ? rd_log[2] : 8'hxx, 2);
        check_lit("pairs_count", pair_log.size(), 2);
        check_lit("pair0", pair_log.size() > 0 ? pair_log[0] : 16'hffff, 16'h0001);
        check_lit("pair1", pair_log.size() > 1 ? pair_log[1] : 16'hffff, 16'h0202);
        check_lit("first_index_latency", first_ready - start_idx, 5);
        check_lit("done_pulses", done_cnt, 1);
        check_lit("jobs_done_at_done", done_jobs, 2);
        check_lit("mu_value", out_mu, 8'h05);
        check_lit("config_value", out_Config, 32'h0005_0201);
        check_lit("busy_after_run", out_busy, 0);

        // Empty descriptor: one read, no grant, done three cycles after start.
        cells[253] = {24'($urandom()), 8'h00};
        build_run(0, 1'b0);
        play();
        check_lit("n0_reads_count", rd_log.size(), 1);
        check_lit("n0_read_addr", rd_log.size() > 0 ? rd_log[0] : 8'hxx, 252);
        check_lit("n0_grant_seen", grant_seen, 0);
        check_lit("n0_done_delay", done_idx - start_idx, 3);

        // Ack and result in the same cycle.
        fill_random(1);
        build_run(2, 1'b0);
        play();
        check_lit("same_cycle_jobs_done", done_jobs, 1);
        check_lit("same_cycle_done_pulses", done_cnt, 1);

        // Reset pulled during RUN, then a fresh run from the descriptor.
        fill_random(3);
        build_run(0, 1'b1);
        play();
        check_lit("abort_busy", out_busy, 0);
        check_lit("abort_grant", out_grant, 0);
        check_lit("abort_jobs_done", out_jobs_done, 0);
        check_lit("abort_no_done", done_cnt, 0);
        fill_random(2);
        build_run(0, 1'b0);
        play();
        check_lit("restart_first_read", rd_log.size() > 0 ? rd_log[0] : 8'hxx, 252);
        check_lit("restart_jobs_done", done_jobs, 2);

        for (int r = 0; r < 15; r++) begin
            fill_random($urandom_range(0, 5));
            build_run($urandom_range(0, 2), 1'b0);
            play();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
